// File: rtl/boundary_value_loader_pkg.sv
// rtl/boundary_value_loader_pkg.sv - shared states and default sizing for the boundary value loader
package boundary_value_loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_APPLY,
    ST_RUN,
    ST_FIN
  } bvl_state_e;

  localparam int BVL_NUM_CELLS = 8;
  localparam int BVL_DATA_W    = 8;
  localparam int BVL_TICK_DIV  = 4;
  localparam int BVL_STEP_W    = 16;
  localparam int BVL_IDX_W     = $clog2(BVL_NUM_CELLS);

endpackage

// File: rtl/boundary_tick_divider.sv
// rtl/boundary_tick_divider.sv - modulo-TICK_DIV counter emitting one tick per wrap
module boundary_tick_divider #(
  parameter int TICK_DIV = 4
) (
  input  logic Clk,
  input  logic Reset,
  input  logic clr,
  input  logic en,
  output logic tick
);

  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  logic [CW-1:0] r_cnt;
  logic          w_wrap;

  assign w_wrap = (r_cnt == CW'(TICK_DIV - 1));
  assign tick   = en && w_wrap;

  always_ff @(posedge Clk) begin
    if (Reset || clr) begin
      r_cnt <= '0;
    end else if (en) begin
      r_cnt <= w_wrap ? '0 : r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/boundary_value_loader.sv
// rtl/boundary_value_loader.sv - loads boundary cell values, applies them, then runs timed ticks (optional BOUNDARY_LOADER_CHECKSUM_EN)
module boundary_value_loader
  import boundary_value_loader_pkg::*;
#(
  parameter int NUM_CELLS = BVL_NUM_CELLS,
  parameter int DATA_W    = BVL_DATA_W,
  parameter int TICK_DIV  = BVL_TICK_DIV,
  parameter int STEP_W    = BVL_STEP_W
) (
  input  logic                        Clk,
  input  logic                        Reset,
  input  logic                        start,
  input  logic [STEP_W-1:0]           num_steps,
  input  logic                        in_valid,
  input  logic [DATA_W-1:0]           in_data,
`ifdef BOUNDARY_LOADER_CHECKSUM_EN
  output logic [DATA_W-1:0]           checksum,
`endif
  output logic                        in_ready,
  output logic [NUM_CELLS*DATA_W-1:0] init_vals,
  output logic                        von_neumann,
  output logic                        tick,
  output logic                        busy,
  output logic                        done
);

  localparam int IW = (NUM_CELLS > 1) ? $clog2(NUM_CELLS) : 1;

  bvl_state_e                        r_state;
  bvl_state_e                        w_next;
  logic [IW-1:0]                     r_idx;
  logic [NUM_CELLS-1:0][DATA_W-1:0]  r_init;
  logic [STEP_W-1:0]                 r_steps;
  logic [STEP_W-1:0]                 r_remain;
  logic                              r_vn;
  logic                              w_in_ready;
  logic                              w_tick;
  logic                              w_done;
  logic                              w_xfer;
  logic                              w_last_byte;
  logic                              w_last_step;
  logic                              w_accept;
  logic                              w_div_tick;

  assign w_accept    = (r_state == ST_IDLE) && start;
  assign w_xfer      = (r_state == ST_LOAD) && in_valid;
  assign w_last_byte = (r_idx == IW'(NUM_CELLS - 1));
  assign w_last_step = (r_remain == STEP_W'(1));

  boundary_tick_divider #(
    .TICK_DIV (TICK_DIV)
  ) u_div (
    .Clk   (Clk),
    .Reset (Reset),
    .clr   (r_state == ST_APPLY),
    .en    (r_state == ST_RUN),
    .tick  (w_div_tick)
  );

  always_comb begin
    w_next     = r_state;
    w_in_ready = 1'b0;
    w_tick     = 1'b0;
    w_done     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start) w_next = ST_LOAD;
      end
      ST_LOAD: begin
        w_in_ready = 1'b1;
        if (w_xfer && w_last_byte) w_next = ST_APPLY;
      end
      ST_APPLY: begin
        w_tick = 1'b1;
        w_next = (r_steps == '0) ? ST_FIN : ST_RUN;
      end
      ST_RUN: begin
        w_tick = w_div_tick;
        if (w_div_tick && w_last_step) w_next = ST_FIN;
      end
      ST_FIN: begin
        w_done = 1'b1;
        w_next = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_state  <= ST_IDLE;
      r_idx    <= '0;
      r_init   <= '0;
      r_steps  <= '0;
      r_remain <= '0;
      r_vn     <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_steps  <= num_steps;
        r_remain <= num_steps;
        r_idx    <= '0;
      end
      if (w_xfer) begin
        r_init[r_idx] <= in_data;
        r_idx         <= r_idx + 1'b1;
      end
      if ((r_state == ST_RUN) && w_div_tick) begin
        r_remain <= r_remain - 1'b1;
      end
      // select follows the state being entered and holds through IDLE/LOAD
      if (w_next == ST_APPLY) begin
        r_vn <= 1'b0;
      end else if ((w_next == ST_RUN) || (w_next == ST_FIN)) begin
        r_vn <= 1'b1;
      end
    end
  end

`ifdef BOUNDARY_LOADER_CHECKSUM_EN
  logic [DATA_W-1:0] r_sum;

  always_ff @(posedge Clk) begin
    if (Reset || w_accept) begin
      r_sum <= '0;
    end else if (w_xfer) begin
      r_sum <= r_sum + in_data;
    end
  end

  assign checksum = r_sum;
`endif

  assign in_ready    = w_in_ready;
  assign init_vals   = r_init;
  assign von_neumann = r_vn;
  assign tick        = w_tick;
  assign busy        = (r_state != ST_IDLE);
  assign done        = w_done;

endmodule

// File: tb/tb_boundary_value_loader.sv
// tb/tb_boundary_value_loader.sv - randomized self-checking bench for boundary_value_loader
module tb_boundary_value_loader;

  localparam int N = 8;
  localparam int W = 8;
  localparam int D = 4;
  localparam int S = 16;

  logic           Clk = 1'b0;
  logic           Reset = 1'b1;
  logic           start = 1'b0;
  logic [S-1:0]   num_steps = '0;
  logic           in_valid = 1'b0;
  logic [W-1:0]   in_data = '0;
  logic           in_ready;
  logic [N*W-1:0] init_vals;
  logic           von_neumann;
  logic           tick;
  logic           busy;
  logic           done;
`ifdef BOUNDARY_LOADER_CHECKSUM_EN
  logic [W-1:0]   checksum;
`endif

  int n_tests = 0;
  int n_fail  = 0;
  logic [W-1:0] model_slots [N];

  boundary_value_loader #(
    .NUM_CELLS (N),
    .DATA_W    (W),
    .TICK_DIV  (D),
    .STEP_W    (S)
  ) dut (
    .Clk         (Clk),
    .Reset       (Reset),
    .start       (start),
    .num_steps   (num_steps),
    .in_valid    (in_valid),
    .in_data     (in_data),
`ifdef BOUNDARY_LOADER_CHECKSUM_EN
    .checksum    (checksum),
`endif
    .in_ready    (in_ready),
    .init_vals   (init_vals),
    .von_neumann (von_neumann),
    .tick        (tick),
    .busy        (busy),
    .done        (done)
  );

  always #5 Clk = ~Clk;

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [N*W-1:0] model_vals();
    logic [N*W-1:0] v;
    for (int k = 0; k < N; k++) v[k*W +: W] = model_slots[k];
    return v;
  endfunction

  task automatic check_reset_outputs(input string tag);
    check({tag, "_init"}, init_vals, 64'h0);
    check({tag, "_vn"}, von_neumann, 0);
    check({tag, "_tick"}, tick, 0);
    check({tag, "_ready"}, in_ready, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
  endtask

  // One full start/load/apply/run/fin sequence; abort_t >= 0 resets at that cycle after APPLY.
  task automatic run_seq(input int steps, input bit gaps, input bit use_fixed,
                         input logic [63:0] fixed, input int abort_t);
    int acc;
    int budget;
    int span;
    logic [W-1:0] b;
    logic [W-1:0] sum;
    bit tick_e;
    check("idle_busy", busy, 0);
    check("idle_ready", in_ready, 0);
    start     = 1'b1;
    num_steps = S'(steps);
    @(negedge Clk);
    start  = 1'b0;
    acc    = 0;
    sum    = '0;
    budget = 0;
`ifdef BOUNDARY_LOADER_CHECKSUM_EN
    check("ck_clear", checksum, 0);
`endif
    while (acc < N && budget < 200) begin
      check("load_ready", in_ready, 1);
      check("load_busy", busy, 1);
      check("load_tick", tick, 0);
      check("load_done", done, 0);
      b        = use_fixed ? fixed[acc*W +: W] : W'($urandom);
      in_valid = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
      in_data  = b;
      start    = 1'($urandom_range(0, 1));
      if (in_valid) begin
        model_slots[acc] = b;
        sum = sum + b;
        acc++;
      end
      budget++;
      @(negedge Clk);
    end
    check("load_count", acc, N);
    start    = 1'b0;
    in_valid = 1'b1;
    in_data  = W'($urandom);
    span     = steps * D;
    for (int t = 0; t <= span + 2; t++) begin
      if (t == abort_t) begin
        Reset = 1'b1;
        @(negedge Clk);
        Reset    = 1'b0;
        in_valid = 1'b0;
        check_reset_outputs("abort");
        @(negedge Clk);
        check("abort_nodone", done, 0);
        check("abort_idle", busy, 0);
        for (int k = 0; k < N; k++) model_slots[k] = '0;
        return;
      end
      tick_e = (t == 0) || (t >= 1 && t <= span && (t % D) == 0);
      check("seq_tick", tick, tick_e);
      check("seq_vn", von_neumann, (t >= 1));
      check("seq_done", done, (t == span + 1));
      check("seq_busy", busy, (t <= span + 1));
      check("seq_ready", in_ready, 0);
      check("seq_init", init_vals, model_vals());
`ifdef BOUNDARY_LOADER_CHECKSUM_EN
      check("seq_ck", checksum, sum);
`endif
      if (t >= 1) in_valid = 1'b0;
      start = (t == 1 && span >= 1);
      @(negedge Clk);
    end
    start = 1'b0;
  endtask

  initial begin
    for (int k = 0; k < N; k++) model_slots[k] = '0;
    repeat (3) @(negedge Clk);
    check_reset_outputs("reset");
    Reset = 1'b0;
    @(negedge Clk);
    check_reset_outputs("post_reset");

    run_seq(0, 1'b0, 1'b1, 64'h8877665544332211, -1);
    check("basic_vals", init_vals, 64'h8877665544332211);
    run_seq(3, 1'b0, 1'b0, 64'h0, -1);
    run_seq(2, 1'b1, 1'b0, 64'h0, -1);
    run_seq(5, 1'b0, 1'b0, 64'h0, D + 1);
    run_seq(1, 1'b0, 1'b0, 64'h0, -1);
`ifdef BOUNDARY_LOADER_CHECKSUM_EN
    run_seq(1, 1'b0, 1'b1, 64'h00000000201001FF, -1);
    check("ck_value", checksum, 8'h30);
    run_seq(0, 1'b1, 1'b0, 64'h0, -1);
`endif
    for (int r = 0; r < 6; r++) begin
      run_seq(int'($urandom_range(0, 4)), 1'($urandom_range(0, 1)), 1'b0, 64'h0, -1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/boundary_value_loader.md
Name: boundary_value_loader

Overview:
- Host-side driver for a row of boundary cells in the physics-accelerator grid.
- Accepts a byte stream of initial boundary values over a valid/ready handshake and presents them on a parallel INIT bus.
- After loading, it pulses the cells' tick once with the INIT value selected, so the cells capture it.
- It then drives the select to NEXT and issues a programmed number of periodic simulation ticks.

Parameters:
- NUM_CELLS, 8, number of boundary cells fed; also the bytes per load.
- DATA_W, 8, width of one cell value.
- TICK_DIV, 4, Clk cycles per simulation tick in RUN; must be ≥1.
- STEP_W, 16, width of the step counter.

Ports:
- Clk, input, 1, system clock; all logic is on the rising edge.
- Reset, input, 1, synchronous, active-high.
- start, input, 1, begins a load+run sequence; sampled only in IDLE.
- num_steps, input, STEP_W, number of RUN ticks; latched when start is accepted.
- in_valid, input, 1, host byte valid.
- in_data, input, DATA_W, host byte.
- in_ready, output, 1, loader can accept a byte.
- init_vals, output, NUM_CELLS*DATA_W, cell k value on bits [k*DATA_W +: DATA_W].
- von_neumann, output, 1, cell mux select: 0 = INIT, 1 = NEXT.
- tick, output, 1, one-cycle cell update enable.
- busy, output, 1, high in any state other than IDLE.
- done, output, 1, one-cycle pulse at the end of a sequence.

Behaviour:
- Reset values: init_vals=0, von_neumann=0, tick=0, in_ready=0, busy=0, done=0. The FSM returns to IDLE, and all counters and the latched step count are cleared. Reset asserted mid-sequence aborts it in the same cycle, with no done pulse.
- States: IDLE, LOAD, APPLY, RUN, FIN.
- IDLE:
  - in_ready=0.
  - start=1 → LOAD next cycle; num_steps is latched and the byte index is cleared.
- LOAD:
  - in_ready=1.
  - A transfer occurs when in_valid&&in_ready. Byte index k writes init_vals[k*DATA_W +: DATA_W] at that edge, then k increments.
  - in_valid low: wait indefinitely; no timeout.
  - The transfer with k==NUM_CELLS-1 → APPLY. in_ready drops the next cycle, so exactly NUM_CELLS bytes are accepted.
  - Unwritten slots keep their previous values; on the first load after reset they are 0.
- APPLY:
  - Lasts exactly one cycle, with tick=1 and von_neumann=0.
  - Next state: latched steps==0 → FIN; otherwise → RUN with the divider cleared.
- RUN:
  - von_neumann=1 throughout.
  - The divider counts 0..TICK_DIV-1. tick=1 in the cycle where divider==TICK_DIV-1, so the first RUN tick occurs TICK_DIV cycles after entering RUN.
  - Each tick decrements the remaining-steps count. The tick that reaches 0 → FIN.
  - With TICK_DIV=1, tick is high every RUN cycle.
- FIN:
  - Lasts one cycle, with done=1 and von_neumann=1.
  - Next state IDLE. von_neumann stays at its last value in IDLE until the next APPLY.
- start outside IDLE is ignored. start held high through FIN restarts in the cycle after returning to IDLE.
- init_vals is held stable in APPLY, RUN, FIN and IDLE.
- Step counter arithmetic is unsigned, and no underflow is possible given the steps==0 check in APPLY.
- The total sequence is NUM_CELLS transfer cycles (when in_valid is held), plus 1 APPLY, plus num_steps*TICK_DIV RUN cycles, plus 1 FIN.

Optional Feature:
- Macro: BOUNDARY_LOADER_CHECKSUM_EN.
- When defined:
  - Adds output checksum[DATA_W-1:0]: the mod-2^DATA_W sum of the bytes accepted in the current LOAD.
  - The sum is cleared when start is accepted, updated on each transfer, and held afterwards. Reset clears it to 0.
- When undefined: the port and its logic are absent, and all other behaviour is identical.

Decomposition:
- A shared package holds:
  - the FSM state enum (IDLE, LOAD, APPLY, RUN, FIN);
  - default constants for DATA_W, NUM_CELLS, TICK_DIV and STEP_W;
  - a helper constant giving the index width, $clog2(NUM_CELLS).
- One sub-module: boundary_tick_divider, a modulo-TICK_DIV counter with clear and enable that outputs the tick pulse. It is used only in RUN.

Test Plan:
- Basic load: NUM_CELLS=8, bytes 0x11..0x88 with in_valid held, num_steps=0 → init_vals=0x8877665544332211; one tick with von_neumann=0; FIN done pulse; total 10 cycles after LOAD entry.
- Run timing: num_steps=3, TICK_DIV=4 → after APPLY, tick at RUN cycles 4, 8 and 12 with von_neumann=1; done the cycle after the third tick; busy low afterwards.
- Backpressure: in_valid toggled 1,0,0,1,... → only handshaken bytes are stored, in order; in_ready drops after the 8th transfer; a 9th valid byte is not accepted.
- Reset mid-RUN after 1 of 5 ticks → next cycle all outputs are at reset values, no done pulse; a fresh start reloads correctly.
- Ignored start: start pulsed during LOAD and RUN → no state change, latched num_steps unchanged.
- Checksum (macro on): bytes 0xFF,0x01,0x10,0x20,0,0,0,0 → checksum=0x30 after LOAD; checksum clears to 0 on the next accepted start.
